// File: rtl/char_action_executor_if.sv
// char_action_executor_if: frame-tick/state inputs and renderer/collision outputs of one player's action executor.
interface char_action_executor_if;
  logic       frame_tick;
  logic [3:0] state_in;
  logic       hit_landed;
  logic [9:0] pos_x;
  logic       hitbox_en;
  logic [9:0] hitbox_x;
  logic [9:0] hitbox_w;
  logic [2:0] sprite_id;
  logic [4:0] anim_frame;
  logic       hit_pulse;
  logic       attack_done;
  modport master(
    output frame_tick, state_in, hit_landed,
    input  pos_x, hitbox_en, hitbox_x, hitbox_w, sprite_id, anim_frame, hit_pulse, attack_done
  );
  modport slave(
    input  frame_tick, state_in, hit_landed,
    output pos_x, hitbox_en, hitbox_x, hitbox_w, sprite_id, anim_frame, hit_pulse, attack_done
  );
endinterface

// File: rtl/char_action_executor.sv
// char_action_executor: executes the character state once per frame (movement, hitbox window, single-hit latch, sprite indices).
module char_action_executor #(
  parameter logic [9:0] X_INIT       = 10'd100,
  parameter logic [9:0] X_MIN        = 10'd0,
  parameter logic [9:0] X_MAX        = 10'd576,
  parameter logic [3:0] MOVE_STEP    = 4'd3,
  parameter logic       FACING_RIGHT = 1'b1,
  parameter logic [9:0] SPRITE_W     = 10'd64,
  parameter logic [9:0] REACH_N      = 10'd24,
  parameter logic [9:0] REACH_D      = 10'd40
) (
  input logic CLOCK,
  input logic RESET_N,
  char_action_executor_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, LEFT, RIGHT, ATK_START, ATK_ACTIVE, ATK_RECOVERY, DIR_START, DIR_ACTIVE, DIR_RECOVERY
  } state_t;
  state_t     prev_state, cur;
  logic       hit_latched, hit, act, done_n, start_n;
  logic [9:0] left_x, right_x, pos_n, w_n, hx;
  logic [2:0] sprite_n;
  logic [4:0] anim_n;
  always_comb begin
    cur      = bus.state_in > 4'd8 ? IDLE : state_t'(bus.state_in);
    left_x   = {1'b0, bus.pos_x} < {1'b0, X_MIN} + 11'(MOVE_STEP) ? X_MIN : bus.pos_x - 10'(MOVE_STEP);
    right_x  = {1'b0, bus.pos_x} + 11'(MOVE_STEP) > {1'b0, X_MAX} ? X_MAX : bus.pos_x + 10'(MOVE_STEP);
    pos_n    = cur == LEFT ? left_x : cur == RIGHT ? right_x : bus.pos_x;
    act      = cur == ATK_ACTIVE || cur == DIR_ACTIVE;
    w_n      = cur == ATK_ACTIVE ? REACH_N : cur == DIR_ACTIVE ? REACH_D : '0;
    hx       = FACING_RIGHT ? pos_n + SPRITE_W : (pos_n < w_n ? '0 : pos_n - w_n);
    sprite_n = cur inside {LEFT, RIGHT}                ? 3'd1 :
               cur inside {ATK_START, DIR_START}       ? 3'd2 :
               cur == ATK_ACTIVE                       ? 3'd3 :
               cur == DIR_ACTIVE                       ? 3'd5 :
               cur inside {ATK_RECOVERY, DIR_RECOVERY} ? 3'd4 : 3'd0;
    anim_n   = cur != prev_state ? 5'd0 : bus.anim_frame == 5'd31 ? 5'd31 : bus.anim_frame + 5'd1;
    // the live hitbox is the registered one, so a hit arriving with the tick that ends the window still counts
    hit      = bus.hitbox_en && bus.hit_landed && !hit_latched;
    done_n   = prev_state inside {ATK_RECOVERY, DIR_RECOVERY} && cur == IDLE;
    start_n  = cur inside {ATK_START, DIR_START};
  end
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      bus.pos_x       <= X_INIT;
      bus.hitbox_en   <= 1'b0;
      bus.hitbox_x    <= '0;
      bus.hitbox_w    <= '0;
      bus.sprite_id   <= '0;
      bus.anim_frame  <= '0;
      bus.hit_pulse   <= 1'b0;
      bus.attack_done <= 1'b0;
      prev_state      <= IDLE;
      hit_latched     <= 1'b0;
    end else begin
      bus.hit_pulse   <= hit;
      bus.attack_done <= bus.frame_tick && done_n;
      hit_latched     <= bus.frame_tick && start_n ? 1'b0 : hit_latched | hit;
      if (bus.frame_tick) begin
        bus.pos_x      <= pos_n;
        bus.hitbox_en  <= act;
        bus.hitbox_x   <= act ? hx : '0;
        bus.hitbox_w   <= w_n;
        bus.sprite_id  <= sprite_n;
        bus.anim_frame <= anim_n;
        prev_state     <= cur;
      end
    end
  end
endmodule

// File: tb/tb_char_action_executor.sv
// tb_char_action_executor: directed checks of movement, hitbox window, hit latch and pulses on two parameterisations.
module tb_char_action_executor;
  logic CLOCK = 1'b0;
  logic RESET_N = 1'b0;
  int checks = 0;
  int errors = 0;
  int hit_cnt = 0;
  char_action_executor_if ifc0();
  char_action_executor_if ifc1();
  assign ifc1.frame_tick = ifc0.frame_tick;
  assign ifc1.state_in   = ifc0.state_in;
  assign ifc1.hit_landed = ifc0.hit_landed;
  char_action_executor dut0 (.CLOCK(CLOCK), .RESET_N(RESET_N), .bus(ifc0.slave));
  char_action_executor #(.X_MAX(10'd110), .FACING_RIGHT(1'b0)) dut1 (.CLOCK(CLOCK), .RESET_N(RESET_N), .bus(ifc1.slave));
  always #5 CLOCK = ~CLOCK;
  always @(negedge CLOCK) if (ifc0.hit_pulse) hit_cnt = hit_cnt + 1;
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
  task automatic apply_reset();
    RESET_N = 1'b0;
    ifc0.frame_tick = 1'b0;
    ifc0.state_in = 4'd0;
    ifc0.hit_landed = 1'b0;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    RESET_N = 1'b1;
  endtask
  task automatic tick(input logic [3:0] s);
    @(negedge CLOCK);
    ifc0.state_in = s;
    ifc0.frame_tick = 1'b1;
    @(posedge CLOCK);
    #1;
    ifc0.frame_tick = 1'b0;
  endtask
  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (ifc0.pos_x !== 10'd100) begin errors++; $display("FAIL reset_pos: got %0d expected 100", ifc0.pos_x); end
    checks++; if ({ifc0.hitbox_en, ifc0.hitbox_x, ifc0.hitbox_w} !== 21'd0) begin errors++; $display("FAIL reset_hitbox: got en=%0b x=%0d w=%0d expected 0", ifc0.hitbox_en, ifc0.hitbox_x, ifc0.hitbox_w); end
    checks++; if ({ifc0.sprite_id, ifc0.anim_frame, ifc0.hit_pulse, ifc0.attack_done} !== 10'd0) begin errors++; $display("FAIL reset_misc: got sprite=%0d anim=%0d hp=%0b ad=%0b expected 0", ifc0.sprite_id, ifc0.anim_frame, ifc0.hit_pulse, ifc0.attack_done); end
    for (int i = 1; i <= 3; i++) begin
      tick(4'd0);
      checks++; if (ifc0.anim_frame !== 5'(i)) begin errors++; $display("FAIL idle_anim: got %0d expected %0d", ifc0.anim_frame, i); end
    end
    repeat (3) @(posedge CLOCK);
    #1;
    checks++; if (ifc0.anim_frame !== 5'd3) begin errors++; $display("FAIL hold_no_tick: got %0d expected 3", ifc0.anim_frame); end
  endtask
  task automatic test_move();
    apply_reset();
    repeat (3) tick(4'd2);
    checks++; if (ifc0.pos_x !== 10'd109) begin errors++; $display("FAIL right3: got %0d expected 109", ifc0.pos_x); end
    checks++; if (ifc0.sprite_id !== 3'd1) begin errors++; $display("FAIL walk_sprite: got %0d expected 1", ifc0.sprite_id); end
    checks++; if (ifc0.anim_frame !== 5'd2) begin errors++; $display("FAIL walk_anim: got %0d expected 2", ifc0.anim_frame); end
    repeat (2) tick(4'd2);
    checks++; if (ifc0.pos_x !== 10'd115) begin errors++; $display("FAIL right5: got %0d expected 115", ifc0.pos_x); end
    checks++; if (ifc1.pos_x !== 10'd110) begin errors++; $display("FAIL right_clamp: got %0d expected 110", ifc1.pos_x); end
    repeat (36) tick(4'd1);
    checks++; if (ifc1.pos_x !== 10'd2) begin errors++; $display("FAIL left36: got %0d expected 2", ifc1.pos_x); end
    repeat (2) tick(4'd1);
    checks++; if (ifc1.pos_x !== 10'd0) begin errors++; $display("FAIL left_clamp: got %0d expected 0", ifc1.pos_x); end
    checks++; if (ifc0.pos_x !== 10'd1) begin errors++; $display("FAIL left_from7: got %0d expected 1", ifc0.pos_x); end
    tick(4'd1);
    checks++; if (ifc0.pos_x !== 10'd0) begin errors++; $display("FAIL left_from1: got %0d expected 0", ifc0.pos_x); end
  endtask
  task automatic test_neutral_attack();
    int en_cnt = 0;
    int done_cnt = 0;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      tick(4'd3);
      en_cnt += int'(ifc0.hitbox_en);
      checks++; if (ifc0.sprite_id !== 3'd2) begin errors++; $display("FAIL startup_sprite: got %0d expected 2", ifc0.sprite_id); end
    end
    for (int i = 0; i < 3; i++) begin
      tick(4'd4);
      en_cnt += int'(ifc0.hitbox_en);
      checks++; if ({ifc0.hitbox_x, ifc0.hitbox_w, ifc0.sprite_id} !== {10'd164, 10'd24, 3'd3}) begin errors++; $display("FAIL active_box: got x=%0d w=%0d sprite=%0d expected 164 24 3", ifc0.hitbox_x, ifc0.hitbox_w, ifc0.sprite_id); end
    end
    for (int i = 0; i < 17; i++) begin
      tick(4'd5);
      en_cnt += int'(ifc0.hitbox_en);
      done_cnt += int'(ifc0.attack_done);
    end
    checks++; if ({ifc0.sprite_id, ifc0.anim_frame, ifc0.hitbox_x} !== {3'd4, 5'd16, 10'd0}) begin errors++; $display("FAIL recovery: got sprite=%0d anim=%0d x=%0d expected 4 16 0", ifc0.sprite_id, ifc0.anim_frame, ifc0.hitbox_x); end
    checks++; if (en_cnt !== 3) begin errors++; $display("FAIL en_window: got %0d expected 3", en_cnt); end
    tick(4'd0);
    checks++; if (ifc0.attack_done !== 1'b1 || done_cnt !== 0) begin errors++; $display("FAIL attack_done: got %0b (earlier %0d) expected 1 (earlier 0)", ifc0.attack_done, done_cnt); end
    @(posedge CLOCK);
    #1;
    checks++; if (ifc0.attack_done !== 1'b0) begin errors++; $display("FAIL attack_done_clear: got %0b expected 0", ifc0.attack_done); end
  endtask
  task automatic test_directional();
    apply_reset();
    tick(4'd6);
    tick(4'd7);
    checks++; if ({ifc1.hitbox_en, ifc1.hitbox_x, ifc1.hitbox_w, ifc1.sprite_id} !== {1'b1, 10'd60, 10'd40, 3'd5}) begin errors++; $display("FAIL dir_left: got en=%0b x=%0d w=%0d sprite=%0d expected 1 60 40 5", ifc1.hitbox_en, ifc1.hitbox_x, ifc1.hitbox_w, ifc1.sprite_id); end
    checks++; if ({ifc0.hitbox_x, ifc0.hitbox_w} !== {10'd164, 10'd40}) begin errors++; $display("FAIL dir_right: got x=%0d w=%0d expected 164 40", ifc0.hitbox_x, ifc0.hitbox_w); end
    tick(4'd8);
    checks++; if ({ifc1.sprite_id, ifc1.hitbox_en} !== {3'd4, 1'b0}) begin errors++; $display("FAIL dir_recovery: got sprite=%0d en=%0b expected 4 0", ifc1.sprite_id, ifc1.hitbox_en); end
    tick(4'd0);
    checks++; if (ifc1.attack_done !== 1'b1) begin errors++; $display("FAIL dir_done: got %0b expected 1", ifc1.attack_done); end
  endtask
  task automatic test_single_hit();
    int base;
    apply_reset();
    base = hit_cnt;
    tick(4'd3);
    ifc0.hit_landed = 1'b1;
    repeat (3) tick(4'd4);
    repeat (2) tick(4'd5);
    ifc0.hit_landed = 1'b0;
    tick(4'd0);
    @(posedge CLOCK);
    checks++; if (hit_cnt - base !== 1) begin errors++; $display("FAIL first_attack_hits: got %0d expected 1", hit_cnt - base); end
    tick(4'd3);
    ifc0.hit_landed = 1'b1;
    repeat (2) tick(4'd4);
    ifc0.hit_landed = 1'b0;
    tick(4'd5);
    tick(4'd0);
    @(posedge CLOCK);
    checks++; if (hit_cnt - base !== 2) begin errors++; $display("FAIL second_attack_hits: got %0d expected 2", hit_cnt - base); end
    tick(4'd3);
    tick(4'd4);
    tick(4'd5);
    ifc0.hit_landed = 1'b1;
    repeat (2) tick(4'd5);
    ifc0.hit_landed = 1'b0;
    tick(4'd0);
    @(posedge CLOCK);
    checks++; if (hit_cnt - base !== 2) begin errors++; $display("FAIL recovery_hit_ignored: got %0d expected 2", hit_cnt - base); end
    tick(4'd3);
    tick(4'd4);
    ifc0.hit_landed = 1'b1;
    tick(4'd5);
    ifc0.hit_landed = 1'b0;
    tick(4'd0);
    @(posedge CLOCK);
    checks++; if (hit_cnt - base !== 3) begin errors++; $display("FAIL hit_on_ending_tick: got %0d expected 3", hit_cnt - base); end
  endtask
  task automatic test_robustness();
    apply_reset();
    tick(4'd2);
    tick(4'hC);
    checks++; if ({ifc0.pos_x, ifc0.sprite_id, ifc0.anim_frame} !== {10'd103, 3'd0, 5'd0}) begin errors++; $display("FAIL illegal_code: got pos=%0d sprite=%0d anim=%0d expected 103 0 0", ifc0.pos_x, ifc0.sprite_id, ifc0.anim_frame); end
    tick(4'd0);
    checks++; if (ifc0.anim_frame !== 5'd1) begin errors++; $display("FAIL illegal_is_idle: got %0d expected 1", ifc0.anim_frame); end
  endtask
  task automatic test_reset_mid_attack();
    int base;
    apply_reset();
    tick(4'd2);
    tick(4'd3);
    tick(4'd4);
    ifc0.hit_landed = 1'b1;
    @(posedge CLOCK);
    #1;
    ifc0.hit_landed = 1'b0;
    RESET_N = 1'b0;
    #1;
    checks++; if ({ifc0.hitbox_en, ifc0.pos_x, ifc0.hit_pulse} !== {1'b0, 10'd100, 1'b0}) begin errors++; $display("FAIL async_reset: got en=%0b pos=%0d hp=%0b expected 0 100 0", ifc0.hitbox_en, ifc0.pos_x, ifc0.hit_pulse); end
    @(negedge CLOCK);
    RESET_N = 1'b1;
    base = hit_cnt;
    tick(4'd4);
    ifc0.hit_landed = 1'b1;
    tick(4'd4);
    ifc0.hit_landed = 1'b0;
    @(posedge CLOCK);
    checks++; if (hit_cnt - base !== 1) begin errors++; $display("FAIL fresh_after_reset: got %0d expected 1", hit_cnt - base); end
  endtask
  initial begin
    ifc0.frame_tick = 1'b0;
    ifc0.state_in = 4'd0;
    ifc0.hit_landed = 1'b0;
    test_reset();
    test_move();
    test_neutral_attack();
    test_directional();
    test_single_hit();
    test_robustness();
    test_reset_mid_attack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
